tbird_tail_lights: RTL and testbench
====================================

# tbird_tail_lights

Thunderbird-style tail-light sequencer: turns `left`/`right`/`haz` driver requests into sequential three-lamp turn signals and a flashing all-on hazard pattern per side. Sits in the vehicle-lighting subsystem between the debounced switch inputs and the lamp drivers. State advances on an internal step tick, optionally slowed by a built-in loadable down-counter prescaler.

## Interface
- `PRESCALE_W`, default 5: prescaler counter width in bits. Used only when `TBIRD_PRESCALE_EN` is defined.
- `PRESCALE_DIV`, default 5'd24: reload value. The step period is `PRESCALE_DIV`+1 clocks. Must fit in `PRESCALE_W` bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `left`  in  1  left turn request, level-sensitive.
- `right`  in  1  right turn request, level-sensitive.
- `haz`  in  1  hazard request, level-sensitive.
- `l_lights`  out  3  left lamps: [0]=LA innermost, [1]=LB, [2]=LC outermost. 1 = lamp on.
- `r_lights`  out  3  right lamps: [0]=RA innermost, [1]=RB, [2]=RC outermost. 1 = lamp on.

## Operation
- Moore FSM with 8 states:
  - IDLE: l=000, r=000
  - L1: l=001
  - L2: l=011
  - L3: l=111
  - R1: r=001
  - R2: r=011
  - R3: r=111
  - LR3: l=111, r=111
- In any state other than LR3, the lamps on the inactive side are off.
- Transitions are evaluated only on a step tick. With no tick, the state holds.
- From IDLE, with priority in this order:
  - `haz`, or `left & right` -> LR3
  - `left` -> L1
  - `right` -> R1
  - otherwise -> IDLE
- L1 -> L2 and L2 -> L3, except that `haz` on the tick goes -> LR3. The same applies to R1 -> R2 -> R3.
- L3 -> IDLE and R3 -> IDLE unconditionally. `haz` is not checked in these states.
- LR3 -> IDLE unconditionally. A held `haz` therefore flashes all lamps: on one step, off the next.
- After IDLE is re-entered, the sequence restarts if the request is still held.
- Dropping `left` or `right` mid-sequence does not abort the sequence; it completes to IDLE.
- Raising the opposite turn input mid-sequence is ignored.
- Unused state encodings must go to IDLE on the next tick.
- Outputs are a pure decode of the state register: no combinational path from the inputs.

## Timing
- `rst` asserted: the state is IDLE and both outputs are 000 immediately, without waiting for a clock edge. The prescaler counter loads `PRESCALE_DIV`.
- `rst` deasserted: the first transition happens on the first tick after release.
- Reset asserted mid-sequence aborts the sequence immediately; there is no completion.
- Inputs are sampled on the clock edge where the tick is high. The new output is visible one clock later: one cycle of latency per step.
- Without the prescaler, the tick is 1 on every cycle. With `right` held from IDLE, `r_lights` reads 001, 011, 111, 000, 001, ... on successive clocks.

## Configuration
- Macro: `TBIRD_PRESCALE_EN`.
- When defined:
  - A `PRESCALE_W`-bit down-counter decrements every clock.
  - When it reaches 0, the tick is asserted for that one cycle and the counter reloads `PRESCALE_DIV` on the same edge.
  - The tick therefore fires every `PRESCALE_DIV`+1 clocks.
  - `PRESCALE_DIV` = 0 gives a tick on every clock.
- When not defined:
  - No counter logic is synthesized.
  - The tick is tied to 1 and the FSM steps every clock.

## Test plan
All scenarios below use the macro undefined and a 10 ns clock.
- Reset: pulse `rst` for 20 ns in the middle of an R2 step -> outputs read 000 asynchronously and stay IDLE after release with all inputs 0.
- Right turn: hold `right`=1 for 4 clocks -> `r_lights` reads 001, 011, 111, 000 and `l_lights` stays 000 throughout.
- Left turn: hold `left`=1 for 4 clocks -> `l_lights` reads 001, 011, 111, 000 and `r_lights` stays 000.
- Hazard preempt: `right` for 1 clock (R1), then `haz` for 1 clock -> next state LR3 with l=111, r=111, then IDLE with 000/000.
- Hazard ignored at L3: `left` for 3 clocks reaching L3, then `haz` -> IDLE (000) first, then LR3 on the following clock.
- Prescaler, with `TBIRD_PRESCALE_EN` defined, `PRESCALE_DIV`=3 and `right` held -> each `r_lights` value holds for exactly 4 clocks.

Source files
------------

// File: rtl/tbird_tail_lights.sv
// Thunderbird tail-light sequencer: three-lamp turn signals and all-lamp hazard flash.
// Define TBIRD_PRESCALE_EN to step the FSM from a loadable down-counter tick.
module tbird_tail_lights #(
    parameter int                    PRESCALE_W   = 5,
    parameter logic [PRESCALE_W-1:0] PRESCALE_DIV = 5'd24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       haz,
    output logic [2:0] l_lights,
    output logic [2:0] r_lights
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   tick;

`ifdef TBIRD_PRESCALE_EN
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == '0);
    assign cnt_d = tick ? PRESCALE_DIV : cnt_q - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= PRESCALE_DIV;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE_DIV;
    assign tick            = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (haz || (left && right)) state_d = LR3;
                    else if (left)              state_d = L1;
                    else if (right)             state_d = R1;
                    else                        state_d = IDLE;
                end
                L1:      state_d = haz ? LR3 : L2;
                L2:      state_d = haz ? LR3 : L3;
                R1:      state_d = haz ? LR3 : R2;
                R2:      state_d = haz ? LR3 : R3;
                // End-of-sequence states ignore haz, giving the on/off flash.
                L3:      state_d = IDLE;
                R3:      state_d = IDLE;
                LR3:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        l_lights = 3'b000;
        r_lights = 3'b000;
        case (state_q)
            L1:  l_lights = 3'b001;
            L2:  l_lights = 3'b011;
            L3:  l_lights = 3'b111;
            R1:  r_lights = 3'b001;
            R2:  r_lights = 3'b011;
            R3:  r_lights = 3'b111;
            LR3: begin
                l_lights = 3'b111;
                r_lights = 3'b111;
            end
            default: begin
                l_lights = 3'b000;
                r_lights = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_tbird_tail_lights.sv
// Directed bench for tbird_tail_lights in the default build (tick every clock).
module tb_tbird_tail_lights;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       haz = 1'b0;
    logic [2:0] l_lights;
    logic [2:0] r_lights;

    int checks = 0;
    int failures = 0;

    tbird_tail_lights dut (
        .clk      (clk),
        .rst      (rst),
        .left     (left),
        .right    (right),
        .haz      (haz),
        .l_lights (l_lights),
        .r_lights (r_lights)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [2:0] zero;
        zero = 3'b000;
        #1;
        checks++;
        if (l_lights !== zero || r_lights !== zero) begin
            failures++;
            $display("FAIL reset_init l=%b r=%b want 000/000", l_lights, r_lights);
        end
        @(negedge clk);
        rst = 1'b0;
        right = 1'b1;
        step();
        step();
        checks++;
        if (r_lights !== 3'b011) begin
            failures++;
            $display("FAIL reset_pre_r2 r=%b want 011", r_lights);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (l_lights !== zero || r_lights !== zero) begin
            failures++;
            $display("FAIL reset_async l=%b r=%b want 000/000", l_lights, r_lights);
        end
        #19;
        rst = 1'b0;
        right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (l_lights !== zero || r_lights !== zero) begin
                failures++;
                $display("FAIL reset_idle[%0d] l=%b r=%b want 000/000",
                         i, l_lights, r_lights);
            end
        end
    endtask

    task automatic test_right;
        logic [2:0] exp_r [4];
        exp_r = '{3'b001, 3'b011, 3'b111, 3'b000};
        right = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (r_lights !== exp_r[i] || l_lights !== 3'b000) begin
                failures++;
                $display("FAIL right[%0d] l=%b r=%b want 000/%b",
                         i, l_lights, r_lights, exp_r[i]);
            end
        end
        right = 1'b0;
        step();
    endtask

    task automatic test_left;
        logic [2:0] exp_l [4];
        exp_l = '{3'b001, 3'b011, 3'b111, 3'b000};
        left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (l_lights !== exp_l[i] || r_lights !== 3'b000) begin
                failures++;
                $display("FAIL left[%0d] l=%b r=%b want %b/000",
                         i, l_lights, r_lights, exp_l[i]);
            end
        end
        left = 1'b0;
        step();
    endtask

    task automatic test_haz_preempt;
        right = 1'b1;
        step();
        checks++;
        if (r_lights !== 3'b001 || l_lights !== 3'b000) begin
            failures++;
            $display("FAIL hzp_r1 l=%b r=%b want 000/001", l_lights, r_lights);
        end
        right = 1'b0;
        haz = 1'b1;
        step();
        checks++;
        if (l_lights !== 3'b111 || r_lights !== 3'b111) begin
            failures++;
            $display("FAIL hzp_lr3 l=%b r=%b want 111/111", l_lights, r_lights);
        end
        haz = 1'b0;
        step();
        checks++;
        if (l_lights !== 3'b000 || r_lights !== 3'b000) begin
            failures++;
            $display("FAIL hzp_idle l=%b r=%b want 000/000", l_lights, r_lights);
        end
    endtask

    task automatic test_haz_at_l3;
        logic [2:0] exp_l [3];
        exp_l = '{3'b001, 3'b011, 3'b111};
        left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (l_lights !== exp_l[i] || r_lights !== 3'b000) begin
                failures++;
                $display("FAIL hz3_seq[%0d] l=%b r=%b want %b/000",
                         i, l_lights, r_lights, exp_l[i]);
            end
        end
        left = 1'b0;
        haz = 1'b1;
        step();
        checks++;
        if (l_lights !== 3'b000 || r_lights !== 3'b000) begin
            failures++;
            $display("FAIL hz3_idle l=%b r=%b want 000/000", l_lights, r_lights);
        end
        step();
        checks++;
        if (l_lights !== 3'b111 || r_lights !== 3'b111) begin
            failures++;
            $display("FAIL hz3_lr3 l=%b r=%b want 111/111", l_lights, r_lights);
        end
        haz = 1'b0;
        step();
    endtask

    task automatic test_haz_flash;
        logic [2:0] exp_v [4];
        exp_v = '{3'b111, 3'b000, 3'b111, 3'b000};
        haz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (l_lights !== exp_v[i] || r_lights !== exp_v[i]) begin
                failures++;
                $display("FAIL flash[%0d] l=%b r=%b want %b/%b",
                         i, l_lights, r_lights, exp_v[i], exp_v[i]);
            end
        end
        haz = 1'b0;
        left = 1'b1;
        right = 1'b1;
        step();
        checks++;
        if (l_lights !== 3'b111 || r_lights !== 3'b111) begin
            failures++;
            $display("FAIL both_lr3 l=%b r=%b want 111/111", l_lights, r_lights);
        end
        left = 1'b0;
        right = 1'b0;
        step();
    endtask

    task automatic test_drop_and_opposite;
        logic [2:0] exp_l [3];
        exp_l = '{3'b011, 3'b111, 3'b000};
        left = 1'b1;
        step();
        left = 1'b0;
        right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (l_lights !== exp_l[i] || r_lights !== 3'b000) begin
                failures++;
                $display("FAIL drop_opp[%0d] l=%b r=%b want %b/000",
                         i, l_lights, r_lights, exp_l[i]);
            end
        end
        step();
        checks++;
        if (r_lights !== 3'b001 || l_lights !== 3'b000) begin
            failures++;
            $display("FAIL opp_restart l=%b r=%b want 000/001", l_lights, r_lights);
        end
        right = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_right();
        test_left();
        test_haz_preempt();
        test_haz_at_l3();
        test_haz_flash();
        test_drop_and_opposite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
